// File: rtl/jxli_fp8_pkg.sv
// jxli_fp8_pkg: shared E4M3 definitions for the FP8 arithmetic blocks.
// Holds the accumulator FSM state enum, the format constants, the unpacked
// operand struct and a normalisation helper. The FP8 multiplier is expected
// to import this package too.
package jxli_fp8_pkg;

    typedef enum logic [3:0] {
        ST_LOADH   = 4'd0,
        ST_LOADL   = 4'd1,
        ST_UNPACK  = 4'd2,
        ST_SPECIAL = 4'd3,
        ST_ALIGN   = 4'd4,
        ST_ADD     = 4'd5,
        ST_NORM    = 4'd6,
        ST_PACK    = 4'd7,
        ST_DONE    = 4'd8
    } state_t;

    localparam int                 BIAS = 7;
    localparam logic signed [4:0]  EMIN = -5'sd6;
    localparam logic signed [4:0]  EMAX = 5'sd7;
    localparam logic [6:0]         INF  = 7'h78;
    localparam logic [7:0]         QNAN = 8'h7F;

    // sig is {carry, hidden, m[2:0]}; carry is always 0 straight out of unpack.
    typedef struct packed {
        logic              sign;
        logic signed [4:0] exp;
        logic [4:0]        sig;
        logic              is_nan;
        logic              is_inf;
        logic              is_zero;
    } fp8_unp_t;

    // True when a non-zero significand still needs a normalisation step:
    // either a carry out of the add, or a missing hidden bit that can still be
    // recovered without dropping below the subnormal exponent.
    function automatic logic needs_norm(input logic signed [4:0] e,
                                        input logic [4:0]        s);
        return (s != 5'd0) && (s[4] || (!s[3] && (e > EMIN)));
    endfunction

endpackage

// File: rtl/jxli_fp8_acc_if.sv
// jxli_fp8_acc_if: nibble-load bus of the E4M3 accumulator.
//   enable  : nibble strobe (high nibble first, then low nibble)
//   clear   : zero the accumulator (only honoured while idle)
//   data    : 4-bit operand nibble
//   acc_out : registered E4M3 accumulator
//   busy    : operation in flight, enable/clear are ignored
//   valid   : one-cycle pulse after acc_out has taken a new sum
// Handshake: a nibble is taken on any rising edge where enable is high and
// the accumulator is waiting for that nibble; there is no backpressure other
// than busy, and anything offered while busy is dropped, not queued.
interface jxli_fp8_acc_if;
    logic       enable;
    logic       clear;
    logic [3:0] data;
    logic [7:0] acc_out;
    logic       busy;
    logic       valid;

    modport master (output enable, clear, data, input acc_out, busy, valid);
    modport slave  (input enable, clear, data, output acc_out, busy, valid);
endinterface

// File: rtl/jxli_fp8_unpack.sv
// jxli_fp8_unpack: combinational E4M3 byte to unpacked-operand converter.
//   bits : E4M3 encoding
//   unp  : sign, unbiased exponent, 5-bit significand and class flags
module jxli_fp8_unpack
    import jxli_fp8_pkg::*;
(
    input  logic [7:0] bits,
    output fp8_unp_t   unp
);

    logic [3:0] e_field;
    logic [2:0] m_field;

    always_comb begin
        e_field     = bits[6:3];
        m_field     = bits[2:0];
        unp         = '0;
        unp.sign    = bits[7];
        unp.is_nan  = (e_field == 4'hF) && (m_field != 3'd0);
        unp.is_inf  = (e_field == 4'hF) && (m_field == 3'd0);
        unp.is_zero = (e_field == 4'h0) && (m_field == 3'd0);
        if (e_field == 4'h0) begin
            // Subnormal/zero: fixed minimum exponent, no hidden bit.
            unp.exp = EMIN;
            unp.sig = {2'b00, m_field};
        end else begin
            unp.exp = $signed({1'b0, e_field}) - 5'sd7;
            unp.sig = {2'b01, m_field};
        end
    end

endmodule

// File: rtl/jxli_fp8_acc.sv
// jxli_fp8_acc: multi-cycle E4M3 accumulator, acc <- acc + x, truncating.
//   clock     : rising-edge clock
//   reset     : synchronous, active-high
//   bus       : jxli_fp8_acc_if slave (enable, clear, data in; acc_out,
//               busy, valid out)
//   state_dbg : current FSM state
// Flow: LOADH/LOADL capture x, UNPACK registers both operands, SPECIAL
// resolves NaN/Inf and orders the operands, ALIGN shifts the smaller one a
// bit per cycle, ADD combines, NORM renormalises a bit per cycle, PACK
// writes the result, DONE pulses valid.
module jxli_fp8_acc
    import jxli_fp8_pkg::*;
(
    input  logic            clock,
    input  logic            reset,
    jxli_fp8_acc_if.slave   bus,
    output state_t          state_dbg
);

    state_t            state, state_nxt;
    logic [7:0]        acc, x;
    fp8_unp_t          x_unp, a_unp, x_r, a_r;

    // L: larger operand, later reused as the running result. S: smaller.
    logic              l_sign, s_sign;
    logic signed [4:0] l_exp, s_exp;
    logic [4:0]        l_sig, s_sig;
    logic [1:0]        shift_cnt;

    logic              special_nan, special_inf, x_bigger, align_last;
    logic signed [4:0] s_exp_inc;
    logic [4:0]        add_raw, add_sig, norm_sig;
    logic signed [4:0] add_exp, norm_exp;
    logic              add_sign;
    logic [3:0]        biased;
    logic [7:0]        pack_byte;

    jxli_fp8_unpack u_unpack_x (.bits(x),   .unp(x_unp));
    jxli_fp8_unpack u_unpack_a (.bits(acc), .unp(a_unp));

    // Datapath combinational helpers.
    always_comb begin
        special_nan = x_r.is_nan || a_r.is_nan ||
                      (x_r.is_inf && a_r.is_inf && (x_r.sign != a_r.sign));
        special_inf = x_r.is_inf || a_r.is_inf;

        // A zero accumulator never outranks a non-zero addend.
        x_bigger = (a_r.is_zero && !x_r.is_zero) ||
                   (x_r.exp > a_r.exp) ||
                   ((x_r.exp == a_r.exp) && (x_r.sig > a_r.sig));

        s_exp_inc  = s_exp + 5'sd1;
        align_last = (s_exp_inc == l_exp) || (shift_cnt == 2'd3);

        // L >= S in magnitude, so the subtraction never wraps.
        add_raw = (l_sign == s_sign) ? (l_sig + s_sig) : (l_sig - s_sig);
        if (add_raw == 5'd0) begin
            // Exact zero: +0 at the subnormal exponent so PACK emits 0x00.
            add_sign = 1'b0;
            add_exp  = EMIN;
            add_sig  = 5'd0;
        end else begin
            add_sign = l_sign;
            add_exp  = l_exp;
            add_sig  = add_raw;
        end

        if (l_sig[4]) begin
            norm_sig = l_sig >> 1;
            norm_exp = l_exp + 5'sd1;
        end else begin
            norm_sig = l_sig << 1;
            norm_exp = l_exp - 5'sd1;
        end

        biased = l_exp[3:0] + 4'(BIAS);
        if (l_exp > EMAX) begin
            pack_byte = {l_sign, INF};
        end else if ((l_exp == EMIN) && !l_sig[3]) begin
            pack_byte = {l_sign, 4'h0, l_sig[2:0]};
        end else begin
            pack_byte = {l_sign, biased, l_sig[2:0]};
        end
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) state <= ST_LOADH;
        else       state <= state_nxt;
    end

    // FSM next state.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_LOADH:   if (!bus.clear && bus.enable) state_nxt = ST_LOADL;
            ST_LOADL:   if (bus.enable) state_nxt = ST_UNPACK;
            ST_UNPACK:  state_nxt = ST_SPECIAL;
            ST_SPECIAL: begin
                if (special_nan || special_inf) state_nxt = ST_DONE;
                else if (x_r.exp == a_r.exp)    state_nxt = ST_ADD;
                else                            state_nxt = ST_ALIGN;
            end
            ST_ALIGN:   if (align_last) state_nxt = ST_ADD;
            ST_ADD:     state_nxt = needs_norm(add_exp, add_sig)   ? ST_NORM : ST_PACK;
            ST_NORM:    state_nxt = needs_norm(norm_exp, norm_sig) ? ST_NORM : ST_PACK;
            ST_PACK:    state_nxt = ST_DONE;
            ST_DONE:    state_nxt = ST_LOADH;
            default:    state_nxt = ST_LOADH;
        endcase
    end

    // Datapath registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            acc       <= 8'h00;
            x         <= 8'h00;
            x_r       <= '0;
            a_r       <= '0;
            l_sign    <= 1'b0;
            l_exp     <= 5'sd0;
            l_sig     <= 5'd0;
            s_sign    <= 1'b0;
            s_exp     <= 5'sd0;
            s_sig     <= 5'd0;
            shift_cnt <= 2'd0;
        end else begin
            case (state)
                ST_LOADH: begin
                    if (bus.clear)       acc     <= 8'h00;
                    else if (bus.enable) x[7:4]  <= bus.data;
                end
                ST_LOADL: if (bus.enable) x[3:0] <= bus.data;
                ST_UNPACK: begin
                    x_r <= x_unp;
                    a_r <= a_unp;
                end
                ST_SPECIAL: begin
                    shift_cnt <= 2'd0;
                    if (special_nan) begin
                        acc <= QNAN;
                    end else if (special_inf) begin
                        acc <= x_r.is_inf ? {x_r.sign, INF} : {a_r.sign, INF};
                    end
                    if (x_bigger) begin
                        {l_sign, l_exp, l_sig} <= {x_r.sign, x_r.exp, x_r.sig};
                        {s_sign, s_exp, s_sig} <= {a_r.sign, a_r.exp, a_r.sig};
                    end else begin
                        {l_sign, l_exp, l_sig} <= {a_r.sign, a_r.exp, a_r.sig};
                        {s_sign, s_exp, s_sig} <= {x_r.sign, x_r.exp, x_r.sig};
                    end
                end
                ST_ALIGN: begin
                    s_sig     <= s_sig >> 1;
                    s_exp     <= s_exp_inc;
                    shift_cnt <= shift_cnt + 2'd1;
                end
                ST_ADD: begin
                    l_sign <= add_sign;
                    l_exp  <= add_exp;
                    l_sig  <= add_sig;
                end
                ST_NORM: begin
                    l_exp <= norm_exp;
                    l_sig <= norm_sig;
                end
                ST_PACK: acc <= pack_byte;
                default: ;
            endcase
        end
    end

    assign bus.acc_out = acc;
    assign bus.busy    = (state != ST_LOADH) && (state != ST_LOADL);
    assign bus.valid   = (state == ST_DONE);
    assign state_dbg   = state;

endmodule
